// File: rtl/game_pkg.sv
// Shared game-flow types: screen state encoding used by the flow controller and the RGB selector.
// Latency: n/a (types only).
// Backpressure: n/a.
package game_pkg;

    // Screen state as seen by the per-pixel RGB selector. 2'b11 is never produced.
    typedef enum logic [1:0] {
        ST_START    = 2'b00,
        ST_GAME     = 2'b01,
        ST_GAMEOVER = 2'b10
    } game_state_t;

endpackage

// File: rtl/game_state_fsm_if.sv
// Player/game-logic/screen signal bundle around the game-flow controller.
// Latency: n/a (wiring only).
// Backpressure: none; every signal is a level or a one-cycle pulse.
// Ports: btn_raw, frame_tick, collision (into controller); state, game_start, jump, game_over (out).
interface game_state_fsm_if;
    import game_pkg::*;

    logic        btn_raw;
    logic        frame_tick;
    logic        collision;
    game_state_t state;
    logic        game_start;
    logic        jump;
    logic        game_over;

    // master: stimulus side (button, video timing, game logic)
    modport master (
        output btn_raw, frame_tick, collision,
        input  state, game_start, jump, game_over
    );

    // slave: the game-flow controller
    modport slave (
        input  btn_raw, frame_tick, collision,
        output state, game_start, jump, game_over
    );
endinterface

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, debounce counter, one-cycle press on debounced rise.
// Latency: press is high 2 + DEBOUNCE_CYCLES cycles after btn_raw rises and stays stable.
// Backpressure: none; presses are pulses, a bouncing input simply restarts the count.
// Ports: clk, rst_n, btn_raw (async raw button), press (one-cycle pulse).
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 650000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);
    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count cycles where the synced level disagrees with the debounced level;
    // any agreement restarts the count, so both press and release are filtered.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;   // rising flip only
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press = press_q;
endmodule

// File: rtl/game_state_fsm.sv
// Game-flow controller: screen state START/GAME/GAME_OVER committed on frame boundaries, plus control pulses.
// Latency: jump 1 cycle after debounced press; state/game_start/game_over at the frame_tick after the request.
// Backpressure: one pending request at a time; further transition events are dropped while it is pending.
// Ports: clk, rst_n, bus (slave: btn_raw, frame_tick, collision in; state, game_start, jump, game_over out).
module game_state_fsm
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 650000,
    parameter int GAMEOVER_FRAMES = 120
) (
    input  logic                   clk,
    input  logic                   rst_n,
    game_state_fsm_if.slave        bus
);
    localparam int            LW       = $clog2(GAMEOVER_FRAMES + 1);
    localparam logic [LW-1:0] LOCK_MAX = LW'(GAMEOVER_FRAMES);

    logic          press;
    logic          commit;

    game_state_t   state_q, state_d;
    game_state_t   pend_tgt_q, pend_tgt_d;
    logic          pend_vld_q, pend_vld_d;
    logic [LW-1:0] lock_q, lock_d;
    logic          game_start_q, game_start_d;
    logic          game_over_q, game_over_d;
    logic          jump_q, jump_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (bus.btn_raw),
        .press   (press)
    );

    // Only a request already pending at the start of the cycle commits, so an
    // event coinciding with frame_tick waits for the following frame.
    assign commit = bus.frame_tick & pend_vld_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_START;
            pend_tgt_q   <= ST_START;
            pend_vld_q   <= 1'b0;
            lock_q       <= '0;
            game_start_q <= 1'b0;
            game_over_q  <= 1'b0;
            jump_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_tgt_q   <= pend_tgt_d;
            pend_vld_q   <= pend_vld_d;
            lock_q       <= lock_d;
            game_start_q <= game_start_d;
            game_over_q  <= game_over_d;
            jump_q       <= jump_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        pend_tgt_d = pend_tgt_q;
        pend_vld_d = pend_vld_q;
        lock_d     = lock_q;
        case (state_q)
            ST_START: begin
                if (!pend_vld_q && press) begin
                    pend_tgt_d = ST_GAME;
                    pend_vld_d = 1'b1;
                end
            end
            ST_GAME: begin
                if (!pend_vld_q && bus.collision) begin
                    pend_tgt_d = ST_GAMEOVER;
                    pend_vld_d = 1'b1;
                end
            end
            ST_GAMEOVER: begin
                if (bus.frame_tick && lock_q < LOCK_MAX)
                    lock_d = lock_q + LW'(1);
                // Presses during lockout are discarded, never queued.
                if (!pend_vld_q && press && lock_q == LOCK_MAX) begin
                    pend_tgt_d = ST_START;
                    pend_vld_d = 1'b1;
                end
            end
            default: begin
                state_d    = ST_START;
                pend_vld_d = 1'b0;
            end
        endcase
        if (commit) begin
            state_d    = pend_tgt_q;
            pend_vld_d = 1'b0;
            if (pend_tgt_q == ST_GAMEOVER)
                lock_d = '0;
        end
    end

    // Output logic (registered pulses, aligned with the committed state)
    always_comb begin
        game_start_d = commit && (pend_tgt_q == ST_GAME);
        game_over_d  = commit && (pend_tgt_q == ST_GAMEOVER);
        // Jumps are not frame-aligned; a collision or a pending game-over suppresses them.
        jump_d       = (state_q == ST_GAME) && press && !pend_vld_q && !bus.collision;
    end

    assign bus.state      = state_q;
    assign bus.game_start = game_start_q;
    assign bus.game_over  = game_over_q;
    assign bus.jump       = jump_q;
endmodule

// File: tb/tb_game_state_fsm.sv
module tb_game_state_fsm;
    import game_pkg::*;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_fail;
    int   n_gs, n_go, n_jmp;   // pulse-cycle counters from the monitor
    int   snap_gs, snap_go, snap_jmp;

    game_state_fsm_if bus ();

    game_state_fsm #(
        .DEBOUNCE_CYCLES (4),
        .GAMEOVER_FRAMES (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.game_start === 1'b1) n_gs  <= n_gs + 1;
        if (bus.game_over  === 1'b1) n_go  <= n_go + 1;
        if (bus.jump       === 1'b1) n_jmp <= n_jmp + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs for the next edge are set 1 time unit after this edge.
    // frame_tick fires at the edge where cyc becomes a multiple of 50.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        bus.collision  = 1'b0;
        bus.frame_tick = ((cyc + 1) % 50 == 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Return just after the next edge at which frame_tick is sampled high.
    task automatic to_frame();
        int n;
        n = 0;
        tick();
        while (!bus.frame_tick && n < 60) begin
            tick();
            n++;
        end
        tick();
    endtask

    // Clean press and release, long enough for both debounce directions.
    task automatic press_release();
        bus.btn_raw = 1'b1;
        ticks(10);
        bus.btn_raw = 1'b0;
        ticks(10);
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; cyc = 0;
        n_gs = 0; n_go = 0; n_jmp = 0;
        rst_n          = 1'b0;
        bus.btn_raw    = 1'b0;
        bus.frame_tick = 1'b0;
        bus.collision  = 1'b0;
        ticks(3);

        // Reset state
        check("rst_state",      32'(bus.state),      32'(ST_START));
        check("rst_game_start", 32'(bus.game_start), 32'd0);
        check("rst_jump",       32'(bus.jump),       32'd0);
        check("rst_game_over",  32'(bus.game_over),  32'd0);
        rst_n = 1'b1;

        // Reset mid-frame with a pending request drops the request
        to_frame();
        bus.btn_raw = 1'b1;
        ticks(10);
        check("pend_no_early_commit", 32'(bus.state), 32'(ST_START));
        snap_gs = n_gs;
        rst_n = 1'b0;
        #2;
        check("midrst_state", 32'(bus.state),      32'(ST_START));
        check("midrst_pulse", 32'(bus.game_start), 32'd0);
        bus.btn_raw = 1'b0;
        ticks(2);
        rst_n = 1'b1;
        to_frame();
        check("midrst_no_commit", 32'(bus.state), 32'(ST_START));
        check("midrst_no_gs",     32'(n_gs - snap_gs), 32'd0);

        // Collision in START is ignored
        bus.collision = 1'b1;
        tick();
        to_frame();
        check("start_coll_state", 32'(bus.state), 32'(ST_START));
        check("start_coll_gs",    32'(n_gs - snap_gs), 32'd0);

        // Bouncing button: one press, START -> GAME at next frame
        for (int i = 0; i < 5; i++) begin
            bus.btn_raw = 1'b1; ticks(2);
            bus.btn_raw = 1'b0; ticks(2);
        end
        bus.btn_raw = 1'b1;
        ticks(10);
        check("bounce_wait_frame", 32'(bus.state), 32'(ST_START));
        to_frame();
        check("bounce_state_game", 32'(bus.state),      32'(ST_GAME));
        check("bounce_gs_high",    32'(bus.game_start), 32'd1);
        tick();
        check("bounce_gs_low",     32'(bus.game_start), 32'd0);
        check("bounce_gs_count",   32'(n_gs - snap_gs), 32'd1);
        bus.btn_raw = 1'b0;
        ticks(10);

        // Three clean presses -> three jumps, 7 cycles after btn_raw rise
        snap_jmp = n_jmp;
        for (int p = 0; p < 3; p++) begin
            bus.btn_raw = 1'b1;
            ticks(6);
            check("jump_not_yet", 32'(bus.jump), 32'd0);
            tick();
            check("jump_at_7",    32'(bus.jump), 32'd1);
            tick();
            check("jump_1cyc",    32'(bus.jump), 32'd0);
            bus.btn_raw = 1'b0;
            ticks(10);
        end
        check("jump_count", 32'(n_jmp - snap_jmp), 32'd3);
        check("jump_state", 32'(bus.state),        32'(ST_GAME));

        // Collision coincident with frame_tick commits one frame later
        snap_go = n_go;
        begin
            int n;
            n = 0;
            while (!bus.frame_tick && n < 60) begin tick(); n++; end
        end
        bus.collision = 1'b1;
        tick();
        check("coinc_no_commit", 32'(bus.state),     32'(ST_GAME));
        check("coinc_no_go",     32'(bus.game_over), 32'd0);
        to_frame();
        check("coinc_state_go",  32'(bus.state),     32'(ST_GAMEOVER));
        check("coinc_go_high",   32'(bus.game_over), 32'd1);
        tick();
        check("coinc_go_low",    32'(bus.game_over), 32'd0);

        // Lockout: press after 1 frame ignored, after 3 frames accepted
        to_frame();
        press_release();
        to_frame();
        check("lock_ignored", 32'(bus.state), 32'(ST_GAMEOVER));
        to_frame();
        check("lock_still_go", 32'(bus.state), 32'(ST_GAMEOVER));
        press_release();
        to_frame();
        check("lock_to_start",  32'(bus.state),      32'(ST_START));
        check("lock_start_nogs", 32'(bus.game_start), 32'd0);
        check("go_count",       32'(n_go - snap_go),  32'd1);

        // Back into GAME, then collision and press in the same cycle
        press_release();
        to_frame();
        check("regame_state", 32'(bus.state), 32'(ST_GAME));
        ticks(2);
        snap_jmp = n_jmp;
        bus.btn_raw = 1'b1;
        ticks(6);
        bus.collision = 1'b1;
        tick();
        check("collpress_no_jump", 32'(bus.jump),  32'd0);
        check("collpress_pending", 32'(bus.state), 32'(ST_GAME));
        bus.btn_raw = 1'b0;
        ticks(3);
        to_frame();
        check("collpress_state_go", 32'(bus.state),     32'(ST_GAMEOVER));
        check("collpress_go_high",  32'(bus.game_over), 32'd1);
        check("collpress_jmp_cnt",  32'(n_jmp - snap_jmp), 32'd0);
        tick();

        // Collision in GAME_OVER is ignored
        snap_go = n_go;
        snap_gs = n_gs;
        bus.collision = 1'b1;
        tick();
        to_frame();
        to_frame();
        check("go_coll_state",  32'(bus.state),       32'(ST_GAMEOVER));
        check("go_coll_pulses", 32'((n_go - snap_go) + (n_gs - snap_gs)), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
